// File: rtl/ifetch_unit_pkg.sv
// Shared fetch definitions: bus widths, default reset PC and the queue entry
// layout used by the fetch unit, decoder and imem wrapper.
package ifetch_unit_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INST_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: DEPTH x fetch_entry_t synchronous FIFO with flush.
// Head is read combinationally so an entry is visible right after its push edge.
module ifetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC register, imem request, prefetch queue and
// redirect flush. Define IFETCH_PERF_EN to add fetch/flush performance counters.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_ad,
    input  logic [INST_W-1:0] imem_out,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef IFETCH_PERF_EN
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed,
`endif
    input  logic              inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      entry;

    assign imem_ad    = pc;
    assign inst_valid = ~empty;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;
    assign pop        = inst_valid & inst_ready;
    assign push       = fetch_en & ~redirect_valid & (~full | pop);
    assign entry      = '{inst: imem_out, pc: pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + 8'd1;
        end
    end

    ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .din  (entry),
        .dout (head),
        .count(count),
        .full (full),
        .empty(empty)
    );

`ifdef IFETCH_PERF_EN
    // Discarded entries exclude the head the decoder consumes on the redirect edge.
    logic [16:0] flush_sum;
    assign flush_sum = 17'(perf_flushed) + 17'(count) - 17'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && perf_fetched != '1) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (redirect_valid) begin
                perf_flushed <= flush_sum[16] ? '1 : flush_sum[15:0];
            end
        end
    end
`else
    logic unused_count;
    assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit; imem is modelled as imem_out = imem_ad ^ 8'hA5.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_en;
    logic [7:0] imem_ad;
    logic [7:0] imem_out;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       inst_valid;
    logic [7:0] inst_data;
    logic [7:0] inst_pc;
    logic       inst_ready;
`ifdef IFETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [7:0] sbq [$];

    always #5 clk = ~clk;
    assign imem_out = imem_ad ^ 8'hA5;

    ifetch_unit #(
        .DEPTH(4),
        .RESET_PC(8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_ad       (imem_ad),
        .imem_out      (imem_out),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
`ifdef IFETCH_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed),
`endif
        .inst_ready    (inst_ready)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pcs(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            sbq.push_back(first + 8'(i));
        end
    endtask

    // Inputs change just after posedge, so at negedge valid&ready is exactly
    // the handshake that the next posedge will perform.
    always @(negedge clk) begin
        if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            pops++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc %h with empty scoreboard", inst_pc);
            end else begin
                logic [7:0] epc;
                epc = sbq.pop_front();
                check("pop_pc", {8'h00, inst_pc}, {8'h00, epc});
                check("pop_data", {8'h00, inst_data}, {8'h00, epc ^ 8'hA5});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fetch_en = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        #2;
        check("rst_imem_ad", {8'h00, imem_ad}, 16'h0000);
        check("rst_valid", {15'd0, inst_valid}, 16'h0000);
        check("rst_data", {8'h00, inst_data}, 16'h0000);
        check("rst_pc", {8'h00, inst_pc}, 16'h0000);

        // Streaming fetch from reset with decoder always ready.
        tick(1);
        rst = 1'b0;
        fetch_en = 1'b1;
        inst_ready = 1'b1;
        expect_pcs(8'h00, 7);
        tick(8);
        inst_ready = 1'b0;

        // Stall until full, then reset mid-stream.
        tick(5);
        check("full_imem_ad", {8'h00, imem_ad}, 16'h000B);
        check("full_valid", {15'd0, inst_valid}, 16'h0001);
        check("full_head_pc", {8'h00, inst_pc}, 16'h0007);
        check("full_head_data", {8'h00, inst_data}, 16'h00A2);
        check("stream_drained", 16'(sbq.size()), 16'h0000);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {15'd0, inst_valid}, 16'h0000);
        check("async_rst_imem_ad", {8'h00, imem_ad}, 16'h0000);
        check("async_rst_pc", {8'h00, inst_pc}, 16'h0000);

        // Fresh fetch with decoder stalled for 10 cycles.
        tick(1);
        rst = 1'b0;
        expect_pcs(8'h00, 2);
        tick(10);
        check("stall_imem_ad", {8'h00, imem_ad}, 16'h0004);
        check("stall_head_pc", {8'h00, inst_pc}, 16'h0000);
        inst_ready = 1'b1;
        tick(1);
        check("fullpop_imem_ad", {8'h00, imem_ad}, 16'h0005);
        check("fullpop_head_pc", {8'h00, inst_pc}, 16'h0001);
        inst_ready = 1'b0;
        tick(1);
        check("still_full_imem_ad", {8'h00, imem_ad}, 16'h0005);
        fetch_en = 1'b0;
        inst_ready = 1'b1;
        tick(1);
        check("three_head_pc", {8'h00, inst_pc}, 16'h0002);
        check("three_imem_ad", {8'h00, imem_ad}, 16'h0005);

        // Redirect with three entries queued and no pop.
        inst_ready = 1'b0;
        fetch_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        tick(1);
        check("redir_valid", {15'd0, inst_valid}, 16'h0000);
        check("redir_imem_ad", {8'h00, imem_ad}, 16'h0080);
        check("redir_sb_empty", 16'(sbq.size()), 16'h0000);
`ifdef IFETCH_PERF_EN
        check("perf_flushed_3", perf_flushed, 16'd3);
`endif
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        expect_pcs(8'h80, 2);
        tick(1);
        check("redir_first_valid", {15'd0, inst_valid}, 16'h0001);
        check("redir_first_pc", {8'h00, inst_pc}, 16'h0080);
        check("redir_first_data", {8'h00, inst_data}, 16'h0025);

        // Redirect to 8'hFE while the head is popped the same cycle.
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        expect_pcs(8'hFE, 4);
        tick(1);
        check("wrap_imem_ad", {8'h00, imem_ad}, 16'h00FE);
        check("wrap_valid", {15'd0, inst_valid}, 16'h0000);
`ifdef IFETCH_PERF_EN
        check("perf_flushed_pop", perf_flushed, 16'd3);
        check("perf_fetched", perf_fetched, 16'd7);
`endif
        redirect_valid = 1'b0;
        tick(4);
        fetch_en = 1'b0;
        tick(4);
        check("drain_valid", {15'd0, inst_valid}, 16'h0000);
        check("drain_imem_ad", {8'h00, imem_ad}, 16'h0002);
        check("final_sb_empty", 16'(sbq.size()), 16'h0000);
        check("total_pops", 16'(pops), 16'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
